// File: rtl/result_uart_tx_if.sv
// Result-to-UART bundle: calculator result handshake on one side, byte-wide UART write port on the other.
// The slave modport is the formatter; the master modport is whatever feeds results and models the UART.
interface result_uart_tx_if;
    logic       result_ready;
    logic [8:0] result;
    logic       sign;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic       overrun;

    modport master (
        output result_ready, result, sign, txready,
        input  txdata, txclk, busy, overrun
    );

    modport slave (
        input  result_ready, result, sign, txready,
        output txdata, txclk, busy, overrun
    );
endinterface

// File: rtl/result_uart_tx.sv
// Captures a signed 9-bit calculator result, converts it to decimal ASCII with a sequential
// double-dabble and streams the bytes to the UART with one txclk strobe per byte.
module result_uart_tx #(
    parameter int SEND_CRLF     = 1,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic             hwclk,
    input  logic             reset,
    result_uart_tx_if.slave  bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CONV     = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;

    localparam int MAX_BYTES = 6;

    logic [2:0]  state_reg;
    logic [8:0]  shift_reg;
    logic        sign_reg;
    logic [11:0] bcd_reg;
    logic [11:0] bcd_adj;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  byte_mem_reg [MAX_BYTES];
    logic [2:0]  byte_cnt_reg;
    logic [2:0]  ptr_reg;
    logic [7:0]  txdata_reg;
    logic        txclk_reg;
    logic        busy_reg;
    logic        overrun_reg;

    logic [7:0]  list_next [MAX_BYTES];
    logic [2:0]  cnt_next;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        supp_hund;
    logic        supp_tens;

    // Add-3 correction on every BCD nibble ahead of the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign hund      = bcd_reg[11:8];
    assign tens      = bcd_reg[7:4];
    assign units     = bcd_reg[3:0];
    assign supp_hund = (ZERO_SUPPRESS != 0) && (hund == 4'd0);
    assign supp_tens = supp_hund && (tens == 4'd0);

    // Ordered byte list; a zero magnitude never gets a minus sign.
    always_comb begin
        for (int i = 0; i < MAX_BYTES; i++) begin
            list_next[i] = 8'h00;
        end
        cnt_next = 3'd0;
        if (sign_reg && (bcd_reg != 12'd0)) begin
            list_next[cnt_next] = 8'h2D;
            cnt_next = cnt_next + 3'd1;
        end
        if (!supp_hund) begin
            list_next[cnt_next] = {4'h3, hund};
            cnt_next = cnt_next + 3'd1;
        end
        if (!supp_tens) begin
            list_next[cnt_next] = {4'h3, tens};
            cnt_next = cnt_next + 3'd1;
        end
        list_next[cnt_next] = {4'h3, units};
        cnt_next = cnt_next + 3'd1;
        if (SEND_CRLF != 0) begin
            list_next[cnt_next] = 8'h0D;
            cnt_next = cnt_next + 3'd1;
            list_next[cnt_next] = 8'h0A;
            cnt_next = cnt_next + 3'd1;
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= 9'd0;
            sign_reg     <= 1'b0;
            bcd_reg      <= 12'd0;
            bit_cnt_reg  <= 4'd0;
            byte_cnt_reg <= 3'd0;
            ptr_reg      <= 3'd0;
            txdata_reg   <= 8'h00;
            txclk_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                byte_mem_reg[i] <= 8'h00;
            end
        end else begin
            txclk_reg <= 1'b0;
            // busy_reg is still high on the final WAIT_ACK->IDLE edge, so a pulse there is dropped.
            overrun_reg <= bus.result_ready && busy_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.result_ready) begin
                        shift_reg   <= bus.result;
                        sign_reg    <= bus.sign;
                        bcd_reg     <= 12'd0;
                        bit_cnt_reg <= 4'd0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_reg     <= {bcd_adj[10:0], shift_reg[8]};
                    shift_reg   <= {shift_reg[7:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd8) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        byte_mem_reg[i] <= list_next[i];
                    end
                    byte_cnt_reg <= cnt_next;
                    ptr_reg      <= 3'd0;
                    state_reg    <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.txready) begin
                        txclk_reg  <= 1'b1;
                        txdata_reg <= byte_mem_reg[ptr_reg];
                        ptr_reg    <= ptr_reg + 3'd1;
                        state_reg  <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // A low txready proves the UART saw the strobe before the next byte goes out.
                    if (!bus.txready) begin
                        if (ptr_reg < byte_cnt_reg) begin
                            state_reg <= ST_SEND;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.txdata  = txdata_reg;
    assign bus.txclk   = txclk_reg;
    assign bus.busy    = busy_reg;
    assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench: dut_a uses CR/LF with zero suppression, dut_b sends three bare digits.
// A small UART model drops txready the cycle after each strobe and logs every byte.
module tb_result_uart_tx;
    logic hwclk = 1'b0;
    logic reset = 1'b1;
    always #5 hwclk = ~hwclk;

    result_uart_tx_if bus_a ();
    result_uart_tx_if bus_b ();

    result_uart_tx #(.SEND_CRLF(1), .ZERO_SUPPRESS(1)) dut_a (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus_a)
    );

    result_uart_tx #(.SEND_CRLF(0), .ZERO_SUPPRESS(0)) dut_b (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus_b)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         drive_cyc = 0;
    int         busy_fall_a = 0;
    logic       busy_prev_a = 1'b0;
    bit         stall_a = 1'b0;
    logic [7:0] rx_a [$];
    logic [7:0] rx_b [$];
    int         sc_a [$];

    always @(posedge hwclk) cyc <= cyc + 1;

    always @(negedge hwclk) begin
        if (bus_a.txclk === 1'b1) begin
            rx_a.push_back(bus_a.txdata);
            sc_a.push_back(cyc);
        end
        if (busy_prev_a === 1'b1 && bus_a.busy === 1'b0) busy_fall_a = cyc;
        busy_prev_a = bus_a.busy;
        bus_a.txready = !(stall_a || bus_a.txclk === 1'b1);
        if (bus_b.txclk === 1'b1) rx_b.push_back(bus_b.txdata);
        bus_b.txready = (bus_b.txclk !== 1'b1);
    end

    task automatic tick();
        @(negedge hwclk);
        #1;
    endtask

    task automatic clear_logs();
        rx_a.delete();
        rx_b.delete();
        sc_a.delete();
    endtask

    task automatic pulse(input int sel, input logic [8:0] v, input logic s);
        if (sel == 0) begin
            bus_a.result = v; bus_a.sign = s; bus_a.result_ready = 1'b1;
        end else begin
            bus_b.result = v; bus_b.sign = s; bus_b.result_ready = 1'b1;
        end
        drive_cyc = cyc;
        tick();
        bus_a.result_ready = 1'b0;
        bus_b.result_ready = 1'b0;
    endtask

    task automatic wait_idle(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (((sel == 0) ? bus_a.busy : bus_b.busy) === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rx_a(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rx_a.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [47:0] pack(input int sel);
        logic [47:0] p;
        p = '0;
        if (sel == 0) foreach (rx_a[i]) p = {p[39:0], rx_a[i]};
        else          foreach (rx_b[i]) p = {p[39:0], rx_b[i]};
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus_a.txdata, bus_a.txclk, bus_a.busy, bus_a.overrun} !== 11'h000) begin
            bad++;
            $display("FAIL reset_a: got txdata=%h txclk=%b busy=%b overrun=%b want 00 0 0 0",
                     bus_a.txdata, bus_a.txclk, bus_a.busy, bus_a.overrun);
        end
        total++;
        if ({bus_b.txdata, bus_b.txclk, bus_b.busy, bus_b.overrun} !== 11'h000) begin
            bad++;
            $display("FAIL reset_b: got txdata=%h txclk=%b busy=%b overrun=%b want 00 0 0 0",
                     bus_b.txdata, bus_b.txclk, bus_b.busy, bus_b.overrun);
        end
        reset = 1'b0;
        tick();
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_basic();
        bit ok;
        clear_logs();
        pulse(0, 9'd123, 1'b0);
        wait_idle(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: busy still %b want 0", bus_a.busy); end
        total++;
        if (sc_a.size() == 0 || (sc_a[0] - drive_cyc) !== 12) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 12", (sc_a.size() == 0) ? -1 : sc_a[0] - drive_cyc);
        end
        total++;
        if (rx_a.size() !== 5 || pack(0) !== 48'h3132330D0A) begin
            bad++;
            $display("FAIL basic_bytes: got n=%0d %h want n=5 3132330d0a", rx_a.size(), pack(0));
        end
        total++;
        if (sc_a.size() == 0 || busy_fall_a !== sc_a[sc_a.size()-1] + 1) begin
            bad++;
            $display("FAIL basic_busy_fall: got cycle %0d want one after last strobe", busy_fall_a);
        end
        $display("basic: 123 -> n=%0d %h", rx_a.size(), pack(0));
    endtask

    task automatic test_formats();
        logic [8:0]  vals [3] = '{9'd7, 9'd0, 9'd100};
        logic        sgns [3] = '{1'b1, 1'b1, 1'b0};
        logic [47:0] exps [3] = '{48'h2D370D0A, 48'h300D0A, 48'h3130300D0A};
        int          lens [3] = '{4, 3, 5};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            pulse(0, vals[k], sgns[k]);
            wait_idle(0, ok);
            total++;
            if (!ok || rx_a.size() !== lens[k] || pack(0) !== exps[k]) begin
                bad++;
                $display("FAIL format_%0d: got n=%0d %h want n=%0d %h", vals[k], rx_a.size(), pack(0), lens[k], exps[k]);
            end
            $display("format: %s%0d -> n=%0d %h", sgns[k] ? "-" : "+", vals[k], rx_a.size(), pack(0));
        end
    endtask

    task automatic test_params();
        logic [8:0]  vals [2] = '{9'd511, 9'd5};
        logic [47:0] exps [2] = '{48'h353131, 48'h303035};
        bit ok;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            pulse(1, vals[k], 1'b0);
            wait_idle(1, ok);
            total++;
            if (!ok || rx_b.size() !== 3 || pack(1) !== exps[k]) begin
                bad++;
                $display("FAIL params_%0d: got n=%0d %h want n=3 %h", vals[k], rx_b.size(), pack(1), exps[k]);
            end
            $display("params: %0d -> n=%0d %h", vals[k], rx_b.size(), pack(1));
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        int errs;
        logic [7:0] held;
        clear_logs();
        pulse(0, 9'd123, 1'b0);
        wait_rx_a(2, ok);
        stall_a = 1'b1;
        tick();
        n = rx_a.size();
        held = bus_a.txdata;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.txclk !== 1'b0 || bus_a.txdata !== held || rx_a.size() != n) errs++;
        end
        total++;
        if (!ok || errs != 0) begin
            bad++;
            $display("FAIL stall_quiet: got %0d disturbed cycles want 0", errs);
        end
        stall_a = 1'b0;
        wait_idle(0, ok);
        total++;
        if (!ok || rx_a.size() !== 5 || pack(0) !== 48'h3132330D0A) begin
            bad++;
            $display("FAIL stall_resume: got n=%0d %h want n=5 3132330d0a", rx_a.size(), pack(0));
        end
        $display("stall: 20 cycles held, stream n=%0d %h", rx_a.size(), pack(0));
    endtask

    task automatic test_overrun();
        bit ok;
        clear_logs();
        pulse(0, 9'd250, 1'b0);
        repeat (3) tick();
        pulse(0, 9'd99, 1'b0);
        total++;
        if (bus_a.overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_pulse: got %b want 1", bus_a.overrun);
        end
        tick();
        total++;
        if (bus_a.overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_width: got %b want 0", bus_a.overrun);
        end
        wait_idle(0, ok);
        total++;
        if (!ok || rx_a.size() !== 5 || pack(0) !== 48'h3235300D0A) begin
            bad++;
            $display("FAIL overrun_first: got n=%0d %h want n=5 3235300d0a", rx_a.size(), pack(0));
        end
        $display("overrun: 250 kept -> %h", pack(0));
        clear_logs();
        tick();
        pulse(0, 9'd99, 1'b0);
        wait_idle(0, ok);
        total++;
        if (!ok || rx_a.size() !== 4 || pack(0) !== 48'h39390D0A) begin
            bad++;
            $display("FAIL overrun_third: got n=%0d %h want n=4 39390d0a", rx_a.size(), pack(0));
        end
        $display("overrun: later 99 -> %h", pack(0));
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        pulse(0, 9'd123, 1'b0);
        wait_rx_a(3, ok);
        reset = 1'b1;
        tick();
        total++;
        if (!ok || bus_a.txclk !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.txdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: got txclk=%b busy=%b txdata=%h want 0 0 00",
                     bus_a.txclk, bus_a.busy, bus_a.txdata);
        end
        reset = 1'b0;
        tick();
        clear_logs();
        pulse(0, 9'd42, 1'b0);
        wait_idle(0, ok);
        total++;
        if (!ok || rx_a.size() !== 4 || pack(0) !== 48'h34320D0A) begin
            bad++;
            $display("FAIL reset_recover: got n=%0d %h want n=4 34320d0a", rx_a.size(), pack(0));
        end
        $display("reset_mid: 42 after abort -> %h", pack(0));
    endtask

    initial begin
        bus_a.result_ready = 1'b0; bus_a.result = 9'd0; bus_a.sign = 1'b0; bus_a.txready = 1'b1;
        bus_b.result_ready = 1'b0; bus_b.result = 9'd0; bus_b.sign = 1'b0; bus_b.txready = 1'b1;
        test_reset();
        test_basic();
        test_formats();
        test_params();
        test_stall();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
